ucie_fdi_hs_responder: RTL

//  Responder end of the FDI clock and rx_active handshakes. Sits on the receive side of the

---
 rtl/ucie_fdi_hs_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ucie_fdi_hs_responder.sv
// ucie_fdi_hs_responder
//   Responder end of the FDI clock and rx_active four-phase handshakes. Ungates
//   the local clock on any request, acknowledges clk_req after ACK_DLY cycles
//   of running clock, grants rx_active when the receive path is ready and keeps
//   the clock running until the receive path has drained.
//
//   Optional feature macro: UCIE_FDI_HS_TIMEOUT_EN
//     defined   : DRAIN gives up after DRAIN_TMO cycles and pulses err_o
//     undefined : DRAIN waits for rx_empty_i forever, err_o tied 0
//
// Parameters
//   ACK_DLY    cycles from clk_en_o rising to clk_ack_o rising (>=1)
//   DRAIN_TMO  drain timeout in cycles (timeout build only)
//
// Ports
//   clk_i, rst_i, swrst_i  clock, sync active-high reset and soft reset
//   clk_req_i / clk_ack_o  clock request / acknowledge
//   rx_active_req_i / rx_active_sts_o  rx_active request / status
//   rx_ready_i, rx_empty_i local receive path ready / drained
//   clk_en_o               local clock-gate enable
//   busy_o                 handshake engine not idle
//   err_o                  one-cycle drain-timeout pulse
module ucie_fdi_hs_responder #(
   parameter int ACK_DLY   = 4,
   parameter int DRAIN_TMO = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic swrst_i,
   input  logic clk_req_i,
   output logic clk_ack_o,
   input  logic rx_active_req_i,
   output logic rx_active_sts_o,
   input  logic rx_ready_i,
   input  logic rx_empty_i,
   output logic clk_en_o,
   output logic busy_o,
   output logic err_o
);

   localparam int CMAX = (ACK_DLY > DRAIN_TMO) ? ACK_DLY : DRAIN_TMO;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UNGATE, S_CLK_ON, S_RX_ACT, S_DRAIN, S_GATE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
`ifdef UCIE_FDI_HS_TIMEOUT_EN
   logic          err_q;
`endif

   // All outputs are registered alongside the state so that ack, status and
   // enable change on the same edge as the state that implies them.
   always_ff @(posedge clk_i) begin
      if (rst_i || swrst_i) begin
         state           <= S_IDLE;
         cnt             <= '0;
         clk_ack_o       <= 1'b0;
         rx_active_sts_o <= 1'b0;
         clk_en_o        <= 1'b0;
         busy_o          <= 1'b0;
`ifdef UCIE_FDI_HS_TIMEOUT_EN
         err_q           <= 1'b0;
`endif
      end else begin
`ifdef UCIE_FDI_HS_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (clk_req_i || rx_active_req_i) begin
                  state    <= S_UNGATE;
                  clk_en_o <= 1'b1;
                  busy_o   <= 1'b1;
                  cnt      <= CW'(ACK_DLY - 1);
               end
            end
            // Requests are not looked at here: once ungating starts the ack
            // always completes and CLK_ON deals with a request that went away.
            S_UNGATE: begin
               if (cnt == '0) begin
                  state     <= S_CLK_ON;
                  clk_ack_o <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // rx_active takes priority over a dropped clk_req: the clock
            // stays on while the receive side still wants it.
            S_CLK_ON: begin
               if (rx_active_req_i) begin
                  if (rx_ready_i) begin
                     state           <= S_RX_ACT;
                     rx_active_sts_o <= 1'b1;
                  end
               end else if (!clk_req_i) begin
                  state     <= S_GATE;
                  clk_ack_o <= 1'b0;
               end
            end
            S_RX_ACT: begin
               if (!rx_active_req_i) begin
                  state <= S_DRAIN;
                  cnt   <= CW'(DRAIN_TMO - 1);
               end
            end
            // Status stays up until the receive path is empty; a new
            // rx_active request is only considered back in CLK_ON.
            S_DRAIN: begin
               if (rx_empty_i) begin
                  state           <= S_CLK_ON;
                  rx_active_sts_o <= 1'b0;
               end
`ifdef UCIE_FDI_HS_TIMEOUT_EN
               else if (cnt == '0) begin
                  state           <= S_CLK_ON;
                  rx_active_sts_o <= 1'b0;
                  err_q           <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
`endif
            end
            // Ack already dropped on entry; the enable follows one cycle later.
            S_GATE: begin
               state    <= S_IDLE;
               clk_en_o <= 1'b0;
               busy_o   <= 1'b0;
            end
            default: begin
               state           <= S_IDLE;
               clk_ack_o       <= 1'b0;
               rx_active_sts_o <= 1'b0;
               clk_en_o        <= 1'b0;
               busy_o          <= 1'b0;
            end
         endcase
      end
   end

`ifdef UCIE_FDI_HS_TIMEOUT_EN
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule
